// File: rtl/gen_sequencer_pkg.sv
// cgol_pkg: shared types and defaults for the Game of Life generation sequencer
package cgol_pkg;
    typedef enum logic [1:0] {S_DISP, S_SNAP, S_CALC} seq_state_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_REGBITS = 3;
    localparam int GEN_CNT_W = 16;
endpackage

// File: rtl/gen_sequencer_if.sv
// gen_sequencer_if: control, load handshake and state-file bus of the sequencer
interface gen_sequencer_if
    import cgol_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int REGBITS = DEF_REGBITS
);
    logic                 run;
    logic                 step;
    logic                 load_valid;
    logic [REGBITS-1:0]   load_row;
    logic [WIDTH-1:0]     load_data;
    logic                 load_ready;
    logic [WIDTH-1:0]     new_r;
    logic [REGBITS-1:0]   addr;
    logic                 prev_we;
    logic                 cur_we;
    logic [WIDTH-1:0]     cur_wd;
    logic                 disp_en;
    logic                 busy;
    logic                 gen_done;
    logic [GEN_CNT_W-1:0] gen_count;
    modport master (
        input  run, step, load_valid, load_row, load_data, new_r,
        output load_ready, addr, prev_we, cur_we, cur_wd, disp_en, busy, gen_done, gen_count
    );
    modport slave (
        output run, step, load_valid, load_row, load_data, new_r,
        input  load_ready, addr, prev_we, cur_we, cur_wd, disp_en, busy, gen_done, gen_count
    );
endinterface

// File: rtl/gen_sequencer_frame_timer.sv
// frame_timer: row scan counter and frames-per-generation counter
module frame_timer #(
    parameter int REGBITS = 3,
    parameter int FRAMES_PER_GEN = 8,
    parameter int FCNT_BITS = 6
) (
    input  logic               ph1,
    input  logic               reset,
    input  logic               stall,
    input  logic               active,
    input  logic               run,
    output logic [REGBITS-1:0] scan_addr,
    output logic               row_last,
    output logic               frame_end,
    output logic               gen_due
);
    logic [FCNT_BITS-1:0] frame_cnt;
    always_comb begin
        row_last = &scan_addr;
        frame_end = active && !stall && row_last;
        gen_due = frame_end && run && frame_cnt == FCNT_BITS'(FRAMES_PER_GEN - 1);
    end
    // the scan counter doubles as the row index of the snapshot and compute phases
    always_ff @(posedge ph1) begin
        if (reset) begin
            scan_addr <= '0;
            frame_cnt <= '0;
        end else begin
            if (!stall) scan_addr <= scan_addr + 1'b1;
            if (frame_end && run) frame_cnt <= gen_due ? '0 : frame_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/gen_sequencer.sv
// gen_sequencer: display scan, pattern load and two-phase generation update control
module gen_sequencer
    import cgol_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int REGBITS = DEF_REGBITS,
    parameter int FRAMES_PER_GEN = 8,
    parameter int FCNT_BITS = 6
) (
    input logic ph1,
    input logic reset,
    gen_sequencer_if.master bus
);
    seq_state_t state, state_n;
    logic [REGBITS-1:0] scan_addr;
    logic row_last, frame_end, gen_due, load, enter_snap, calc_end, step_pend, gen_done;
    logic [GEN_CNT_W-1:0] gen_count;
    frame_timer #(
        .REGBITS(REGBITS),
        .FRAMES_PER_GEN(FRAMES_PER_GEN),
        .FCNT_BITS(FCNT_BITS)
    ) u_timer (
        .ph1(ph1),
        .reset(reset),
        .stall(load),
        .active(state == S_DISP),
        .run(bus.run),
        .scan_addr(scan_addr),
        .row_last(row_last),
        .frame_end(frame_end),
        .gen_due(gen_due)
    );
    always_ff @(posedge ph1) state <= reset ? S_DISP : state_n;
    // a load stretches the frame, so a due trigger simply slips to the real frame end
    always_comb begin
        load = state == S_DISP && bus.load_valid;
        state_n = state;
        if (state == S_DISP && (gen_due || (frame_end && !bus.run && step_pend))) state_n = S_SNAP;
        if (state != S_DISP && row_last) state_n = state == S_SNAP ? S_CALC : S_DISP;
        enter_snap = state == S_DISP && state_n == S_SNAP;
        calc_end = state == S_CALC && row_last;
        bus.load_ready = state == S_DISP;
        bus.addr = load ? bus.load_row : scan_addr;
        bus.prev_we = state == S_SNAP;
        bus.cur_we = load || state == S_CALC;
        bus.cur_wd = load ? bus.load_data : (state == S_CALC ? bus.new_r : WIDTH'(0));
        bus.disp_en = state == S_DISP && !load;
        bus.busy = state != S_DISP;
        bus.gen_done = gen_done;
        bus.gen_count = gen_count;
    end
    always_ff @(posedge ph1) begin
        if (reset) begin
            step_pend <= 1'b0;
            gen_done <= 1'b0;
            gen_count <= '0;
        end else begin
            step_pend <= (bus.step && !bus.run) || (step_pend && !enter_snap);
            gen_done <= calc_end;
            gen_count <= gen_count + GEN_CNT_W'(calc_end);
        end
    end
endmodule

// File: tb/tb_gen_sequencer.sv
// tb_gen_sequencer: directed stimulus with a queued per-cycle expectation scoreboard
module tb_gen_sequencer;
    typedef struct packed {
        logic [2:0]  addr;
        logic        prev_we;
        logic        cur_we;
        logic [7:0]  cur_wd;
        logic        disp_en;
        logic        load_ready;
        logic        busy;
        logic        gen_done;
        logic [15:0] gen_count;
    } exp_t;

    logic ph1 = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    exp_t exp_q[$];
    string tag_q[$];

    gen_sequencer_if bus ();
    gen_sequencer #(.FRAMES_PER_GEN(2)) dut (.ph1(ph1), .reset(reset), .bus(bus.master));

    always #5 ph1 = ~ph1;

    function automatic exp_t e_disp(input int a, input int gc, input bit gd);
        return '{addr: 3'(a), prev_we: 0, cur_we: 0, cur_wd: 0, disp_en: 1, load_ready: 1,
                 busy: 0, gen_done: gd, gen_count: 16'(gc)};
    endfunction
    function automatic exp_t e_load(input int a, input int d, input int gc, input bit gd);
        return '{addr: 3'(a), prev_we: 0, cur_we: 1, cur_wd: 8'(d), disp_en: 0, load_ready: 1,
                 busy: 0, gen_done: gd, gen_count: 16'(gc)};
    endfunction
    function automatic exp_t e_snap(input int a, input int gc);
        return '{addr: 3'(a), prev_we: 1, cur_we: 0, cur_wd: 0, disp_en: 0, load_ready: 0,
                 busy: 1, gen_done: 0, gen_count: 16'(gc)};
    endfunction
    function automatic exp_t e_calc(input int a, input int d, input int gc);
        return '{addr: 3'(a), prev_we: 0, cur_we: 1, cur_wd: 8'(d), disp_en: 0, load_ready: 0,
                 busy: 1, gen_done: 0, gen_count: 16'(gc)};
    endfunction
    function automatic string fmt(input exp_t v);
        return $sformatf("addr=%0d pwe=%b cwe=%b wd=%h den=%b lrdy=%b busy=%b gdone=%b gcnt=%0d",
                         v.addr, v.prev_we, v.cur_we, v.cur_wd, v.disp_en, v.load_ready,
                         v.busy, v.gen_done, v.gen_count);
    endfunction

    task automatic cyc(input logic rs, input logic rn, input logic st, input logic lv,
                       input logic [2:0] lr, input logic [7:0] ld, input logic [7:0] nr,
                       input exp_t e, input string tag);
        @(negedge ph1);
        reset = rs;
        bus.run = rn;
        bus.step = st;
        bus.load_valid = lv;
        bus.load_row = lr;
        bus.load_data = ld;
        bus.new_r = nr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask
    task automatic t_disp(input logic rn, input logic st, input int a, input int gc, input bit gd,
                          input string tag);
        cyc(0, rn, st, 0, 0, 0, 0, e_disp(a, gc, gd), $sformatf("%s_disp%0d", tag, a));
    endtask
    task automatic t_snap(input logic rn, input int gc, input string tag);
        for (int r = 0; r < 8; r++)
            cyc(0, rn, 0, 0, 0, 0, 8'hee, e_snap(r, gc), $sformatf("%s_snap%0d", tag, r));
    endtask
    task automatic t_calc(input logic rn, input logic [7:0] step_m, input logic [7:0] load_m,
                          input int gc, input string tag);
        for (int r = 0; r < 8; r++)
            cyc(0, rn, step_m[r], load_m[r], 3'd5, 8'h3c, 8'(8'h40 + r), e_calc(r, 8'h40 + r, gc),
                $sformatf("%s_calc%0d", tag, r));
    endtask

    initial begin : monitor
        exp_t e, got;
        string tg;
        forever begin
            @(negedge ph1);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tg = tag_q.pop_front();
                got = {bus.addr, bus.prev_we, bus.cur_we, bus.cur_wd, bus.disp_en,
                       bus.load_ready, bus.busy, bus.gen_done, bus.gen_count};
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL %s: got %s / want %s", tg, fmt(got), fmt(e));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin : stim
        bus.run = 0;
        bus.step = 0;
        bus.load_valid = 0;
        bus.load_row = 0;
        bus.load_data = 0;
        bus.new_r = 0;
        cyc(1, 0, 0, 0, 0, 0, 0, e_disp(0, 0, 0), "reset0");
        cyc(1, 0, 1, 1, 3'd6, 8'hff, 0, e_load(6, 8'hff, 0, 0), "reset1_load");
        // free scan after reset
        for (int i = 0; i < 20; i++) t_disp(0, 0, i % 8, 0, 0, "scan");
        // load stretches the frame; scan resumes at the held row
        cyc(0, 0, 0, 1, 3'd3, 8'h18, 0, e_load(3, 8'h18, 0, 0), "load_r3");
        for (int a = 4; a < 8; a++) t_disp(0, 0, a, 0, 0, "after_load");
        // run with two frames per generation
        for (int g = 1; g <= 2; g++) begin
            for (int i = 0; i < 16; i++) t_disp(1, 0, i % 8, g - 1, g == 2 && i == 0, $sformatf("run_g%0d", g));
            t_snap(1, g - 1, $sformatf("run_g%0d", g));
            t_calc(1, 8'h00, 8'h00, g - 1, $sformatf("run_g%0d", g));
        end
        t_disp(0, 0, 0, 2, 1, "run_done2");
        // step mid-frame, second step during calc, third absorbed
        t_disp(0, 0, 1, 2, 0, "step");
        t_disp(0, 1, 2, 2, 0, "step_pulse");
        for (int a = 3; a < 8; a++) t_disp(0, 0, a, 2, 0, "step_wait");
        t_snap(0, 2, "step_g3");
        t_calc(0, 8'b0010_0100, 8'h00, 2, "step_g3");
        for (int a = 0; a < 8; a++) t_disp(0, 0, a, 3, a == 0, "step2_wait");
        t_snap(0, 3, "step_g4");
        t_calc(0, 8'h00, 8'h00, 3, "step_g4");
        t_disp(0, 0, 0, 4, 1, "step_done4");
        for (int i = 1; i < 16; i++) t_disp(0, 0, i % 8, 4, 0, "no_extra");
        // load held through calc is accepted on the first display cycle
        t_disp(0, 1, 0, 4, 0, "ld_step");
        for (int a = 1; a < 8; a++) t_disp(0, 0, a, 4, 0, "ld_wait");
        t_snap(0, 4, "ld_g5");
        t_calc(0, 8'h00, 8'hf0, 4, "ld_g5");
        cyc(0, 0, 0, 1, 3'd5, 8'h3c, 0, e_load(5, 8'h3c, 5, 1), "ld_accept");
        t_disp(0, 0, 0, 5, 0, "ld_after");
        t_disp(0, 0, 1, 5, 0, "ld_after");
        // reset in the middle of calc abandons the generation
        t_disp(0, 1, 2, 5, 0, "rst_step");
        for (int a = 3; a < 8; a++) t_disp(0, 0, a, 5, 0, "rst_wait");
        t_snap(0, 5, "rst_g6");
        for (int r = 0; r < 4; r++)
            cyc(0, 0, 0, 0, 0, 0, 8'(8'h40 + r), e_calc(r, 8'h40 + r, 5), $sformatf("rst_calc%0d", r));
        cyc(1, 0, 0, 0, 0, 0, 8'h44, e_calc(4, 8'h44, 5), "rst_calc4");
        t_disp(0, 0, 0, 0, 0, "rst_after");
        t_disp(0, 0, 1, 0, 0, "rst_after");
        @(negedge ph1);
        #4;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked / want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
